lfsr_word_gen: RTL and testbench
================================

# lfsr_word_gen

Parametrised pseudo-random word generator: an N-bit LFSR selectable between Fibonacci and Galois form. Its serial output is packed into WORD_BITS-wide words and offered on a valid/ready handshake. The block supports runtime reseeding with all-zero lockup protection, and replaces the single-bit `lfsr` wherever consumers need whole random words with back-pressure, such as noise sources, dither and test-pattern feeds.

## Interface
- NUM_BITS, 16: LFSR length. Range 2..32.
- TAPS, 16'hB400: tap mask. Bit i set means state bit i participates.
- SEED, 16'h0001: reset and fallback seed. Must be nonzero; elaboration error if zero.
- WORD_BITS, 8: output word width. Range 1..32.
- GALOIS, 0: 0 selects Fibonacci, 1 selects Galois.
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- enable  in  1  advance LFSR one step per cycle when high
- reseed  in  1  load seed_in this cycle
- seed_in  in  NUM_BITS  new seed
- random_bit  out  1  registered serial output
- word_out  out  WORD_BITS  packed word; stable while word_valid
- word_valid  out  1  word_out holds an unconsumed word
- word_ready  in  1  consumer accepts word_out
- lockup  out  1  one-cycle pulse when a zero seed was replaced by SEED

## Operation
- State `sr[NUM_BITS-1:0]`. Output bit of a step is `sr[NUM_BITS-1]`, taken before the step.
- Fibonacci step: `sr <= {sr[NUM_BITS-2:0], ^(sr & TAPS)}`.
- Galois step: `sr <= {sr[NUM_BITS-2:0], 1'b0} ^ (sr[NUM_BITS-1] ? TAPS : 0)`.
- advance = enable && !reseed && !stall.
- stall = (bit_cnt == WORD_BITS-1) && word_valid && !word_ready. The generator freezes rather than dropping a word.
- On advance:
  - random_bit <= sr[NUM_BITS-1].
  - shift_word <= {shift_word[WORD_BITS-2:0], sr[NUM_BITS-1]}. The first bit of a word ends up in the MSB.
  - bit_cnt increments. At WORD_BITS-1 it wraps to 0, word_out is loaded with the completed word, and word_valid is set.
- Handshake: a word transfers on a posedge with word_valid && word_ready. word_valid then clears, unless a new word completes on the same edge; in that case word_out is replaced and word_valid stays 1.
- Reseed:
  - Has priority over advance.
  - Loads seed_in into sr, or SEED if seed_in == 0, in which case lockup pulses for one cycle.
  - Clears bit_cnt and shift_word.
  - A pending word_out/word_valid is kept, and the handshake still operates that cycle.
- Reset values: sr = SEED, random_bit = 0, shift_word = 0, bit_cnt = 0, word_out = 0, word_valid = 0, lockup = 0.

## Timing
- random_bit reflects a step 1 cycle after the advancing edge.
- word_valid rises on the same edge as the WORD_BITS-th advance of the word.
- Throughput: one word per WORD_BITS enabled, unstalled cycles. No bubble when word_ready is held high.
- enable low: state, counter and outputs hold. Handshake still completes.
- Reset mid-word: all state returns to reset values immediately (asynchronous). Deassertion is synchronised by the integrator.
- reseed and stall in the same cycle: reseed wins. bit_cnt clears, so the stall releases next cycle.

## Structure
- Package `lfsr_pkg`:
  - MODE_FIBONACCI = 0, MODE_GALOIS = 1.
  - Maximal-length tap constants TAPS_4 = 4'h9, TAPS_5 = 5'h12, TAPS_16 = 16'hB400.
  - Max width constant 32.
- Sub-module `lfsr_core` holds the state register, step logic (generate on GALOIS), reseed mux and zero-seed guard.
- Top holds the collector, counter and handshake.

## Test plan
- NUM_BITS=5, TAPS=5'h12, SEED=1, Fibonacci, WORD_BITS=5, ready=1, enable=1 -> states 00001, 00010, 00101, 01010, 10101, 01011. random_bit 0, 0, 0, 0, 1. First word_out = 5'b00001.
- Same config, 31 advances -> sr returns to 5'b00001, all 31 nonzero states visited once. NUM_BITS=4, TAPS=4'h3, Galois -> period 15.
- WORD_BITS=8, ready=0 -> after 8 advances word_valid=1. The generator stalls with bit_cnt=7 and word_out unchanged. Raising ready for one cycle -> transfer, and the next word completes 1 cycle later.
- reseed=1 with seed_in=0 -> sr=SEED, lockup high for exactly 1 cycle. reseed with seed_in=5'h1F -> sr=5'h1F, lockup=0, bit_cnt=0, existing word_valid retained.
- Word completes on the same edge as acceptance with ready=1 -> word_valid stays 1 and word_out shows the new word, with no gap.
- rst_n pulsed low mid-word (bit_cnt=3, word_valid=1) -> all outputs 0 and sr=SEED immediately. The first word after reset matches the first-word value.

Source files
------------

// File: rtl/lfsr_pkg.sv
// Shared constants for the LFSR word generator: mode selectors,
// known maximal-length tap masks and width limits.
package lfsr_pkg;

  localparam int MODE_FIBONACCI = 0;
  localparam int MODE_GALOIS    = 1;

  localparam logic [3:0]  TAPS_4  = 4'h9;
  localparam logic [4:0]  TAPS_5  = 5'h12;
  localparam logic [15:0] TAPS_16 = 16'hB400;

  localparam int LFSR_MAX_WIDTH = 32;

  // Counter width able to hold 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lfsr_core.sv
// LFSR state register with Fibonacci or Galois stepping, reseed mux and
// zero-seed guard. Exposes only the bit that the next step shifts out.
module lfsr_core
  import lfsr_pkg::*;
#(
  parameter int                  NUM_BITS = 16,
  parameter logic [NUM_BITS-1:0] TAPS     = TAPS_16,
  parameter logic [NUM_BITS-1:0] SEED     = 16'h0001,
  parameter int                  GALOIS   = MODE_FIBONACCI
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                advance_i,
  input  logic                reseed_i,
  input  logic [NUM_BITS-1:0] seed_i,
  output logic                msb_o,
  output logic                lockup_o
);

  logic [NUM_BITS-1:0] sr_q, sr_d, step_w;
  logic                lockup_q, lockup_d;

  generate
    if (SEED == '0) begin : g_bad_seed
      $error("lfsr_core: SEED must be nonzero");
    end
    if (NUM_BITS < 2 || NUM_BITS > LFSR_MAX_WIDTH) begin : g_bad_width
      $error("lfsr_core: NUM_BITS out of range 2..32");
    end
    if (GALOIS == MODE_GALOIS) begin : g_galois
      // Galois: shift left, fold the outgoing bit into every tap position.
      assign step_w = {sr_q[NUM_BITS-2:0], 1'b0} ^ (sr_q[NUM_BITS-1] ? TAPS : '0);
    end else begin : g_fibonacci
      // Fibonacci: shift left, feed the parity of the tapped bits in at bit 0.
      assign step_w = {sr_q[NUM_BITS-2:0], ^(sr_q & TAPS)};
    end
  endgenerate

  // Next state: reseed beats advance; a zero seed is swapped for SEED so the
  // register can never lock up in the all-zero state.
  always_comb begin
    sr_d     = sr_q;
    lockup_d = 1'b0;
    if (reseed_i) begin
      if (seed_i == '0) begin
        sr_d     = SEED;
        lockup_d = 1'b1;
      end else begin
        sr_d = seed_i;
      end
    end else if (advance_i) begin
      sr_d = step_w;
    end
  end

  // State and lockup pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q     <= SEED;
      lockup_q <= 1'b0;
    end else begin
      sr_q     <= sr_d;
      lockup_q <= lockup_d;
    end
  end

  assign msb_o    = sr_q[NUM_BITS-1];
  assign lockup_o = lockup_q;

endmodule

// File: rtl/lfsr_word_gen.sv
// Pseudo-random word generator: packs the LFSR serial stream MSB-first into
// WORD_BITS-wide words offered on a valid/ready handshake. The generator
// freezes on the last bit of a word rather than overwrite an unread word.
module lfsr_word_gen
  import lfsr_pkg::*;
#(
  parameter int                  NUM_BITS  = 16,
  parameter logic [NUM_BITS-1:0] TAPS      = TAPS_16,
  parameter logic [NUM_BITS-1:0] SEED      = 16'h0001,
  parameter int                  WORD_BITS = 8,
  parameter int                  GALOIS    = MODE_FIBONACCI
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 reseed,
  input  logic [NUM_BITS-1:0]  seed_in,
  output logic                 random_bit,
  output logic [WORD_BITS-1:0] word_out,
  output logic                 word_valid,
  input  logic                 word_ready,
  output logic                 lockup
);

  localparam int             CNT_W    = cnt_width(WORD_BITS);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_BITS - 1);

  generate
    if (WORD_BITS < 1 || WORD_BITS > LFSR_MAX_WIDTH) begin : g_bad_word
      $error("lfsr_word_gen: WORD_BITS out of range 1..32");
    end
  endgenerate

  logic                 msb_w, last_w, stall_w, advance_w, complete_w, accept_w;
  logic [WORD_BITS-1:0] word_next_w;

  logic                 random_bit_q, random_bit_d;
  logic [WORD_BITS-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [WORD_BITS-1:0] word_out_q, word_out_d;
  logic                 word_valid_q, word_valid_d;

  assign last_w     = (bit_cnt_q == LAST_BIT);
  assign stall_w    = last_w && word_valid_q && !word_ready;
  assign advance_w  = enable && !reseed && !stall_w;
  assign complete_w = advance_w && last_w;
  assign accept_w   = word_valid_q && word_ready;

  generate
    if (WORD_BITS == 1) begin : g_word1
      assign word_next_w = msb_w;
    end else begin : g_wordn
      assign word_next_w = {shift_q[WORD_BITS-2:0], msb_w};
    end
  endgenerate

  lfsr_core #(
    .NUM_BITS (NUM_BITS),
    .TAPS     (TAPS),
    .SEED     (SEED),
    .GALOIS   (GALOIS)
  ) u_core (
    .clk       (clk),
    .rst_n     (rst_n),
    .advance_i (advance_w),
    .reseed_i  (reseed),
    .seed_i    (seed_in),
    .msb_o     (msb_w),
    .lockup_o  (lockup)
  );

  // Collector and handshake: a completing word may replace the one being
  // accepted on the same edge, keeping word_valid high with no bubble.
  always_comb begin
    random_bit_d = random_bit_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    word_out_d   = word_out_q;
    word_valid_d = word_valid_q;
    if (accept_w) begin
      word_valid_d = 1'b0;
    end
    if (reseed) begin
      shift_d   = '0;
      bit_cnt_d = '0;
    end else if (advance_w) begin
      random_bit_d = msb_w;
      shift_d      = word_next_w;
      if (complete_w) begin
        bit_cnt_d    = '0;
        word_out_d   = word_next_w;
        word_valid_d = 1'b1;
      end else begin
        bit_cnt_d = bit_cnt_q + 1'b1;
      end
    end
  end

  // Collector state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      random_bit_q <= 1'b0;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      word_out_q   <= '0;
      word_valid_q <= 1'b0;
    end else begin
      random_bit_q <= random_bit_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      word_out_q   <= word_out_d;
      word_valid_q <= word_valid_d;
    end
  end

  assign random_bit = random_bit_q;
  assign word_out   = word_out_q;
  assign word_valid = word_valid_q;

endmodule

// File: tb/tb_lfsr_word_gen.sv
// Bench for lfsr_word_gen: three configurations (5-bit Fibonacci / 5-bit
// words, 4-bit Galois / 3-bit words, 16-bit Fibonacci / 8-bit words) run
// against a sequence-level reference model, plus literal expectations.
module tb_lfsr_word_gen;

  localparam int          CFG_N    [3] = '{5, 4, 16};
  localparam int          CFG_W    [3] = '{5, 3, 8};
  localparam int          CFG_GAL  [3] = '{0, 1, 0};
  localparam logic [31:0] CFG_TAPS [3] = '{32'h12, 32'h3, 32'hB400};
  localparam logic [31:0] CFG_SEED [3] = '{32'h1, 32'h1, 32'h1};

  typedef struct {
    logic [31:0] sr;
    logic [31:0] acc;
    int          nbits;
    logic [31:0] wo;
    logic        rb;
    logic        wv;
    logic        lk;
  } mstate_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic        en  [3];
  logic        rs  [3];
  logic [31:0] sd  [3];
  logic        rdy [3];

  logic        out_rb [3];
  logic [31:0] out_wo [3];
  logic        out_wv [3];
  logic        out_lk [3];

  logic [4:0]  wo_a;
  logic [2:0]  wo_b;
  logic [7:0]  wo_c;

  mstate_t m_q [3];
  int  tests = 0;
  int  fails = 0;
  bit  cmp_en = 1'b0;

  always #5 clk = ~clk;

  lfsr_word_gen #(.NUM_BITS(5), .TAPS(5'h12), .SEED(5'h01), .WORD_BITS(5), .GALOIS(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .enable(en[0]), .reseed(rs[0]), .seed_in(sd[0][4:0]),
    .random_bit(out_rb[0]), .word_out(wo_a), .word_valid(out_wv[0]),
    .word_ready(rdy[0]), .lockup(out_lk[0]));

  lfsr_word_gen #(.NUM_BITS(4), .TAPS(4'h3), .SEED(4'h1), .WORD_BITS(3), .GALOIS(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .enable(en[1]), .reseed(rs[1]), .seed_in(sd[1][3:0]),
    .random_bit(out_rb[1]), .word_out(wo_b), .word_valid(out_wv[1]),
    .word_ready(rdy[1]), .lockup(out_lk[1]));

  lfsr_word_gen #(.NUM_BITS(16), .TAPS(16'hB400), .SEED(16'h0001), .WORD_BITS(8), .GALOIS(0)) dut_c (
    .clk(clk), .rst_n(rst_n), .enable(en[2]), .reseed(rs[2]), .seed_in(sd[2][15:0]),
    .random_bit(out_rb[2]), .word_out(wo_c), .word_valid(out_wv[2]),
    .word_ready(rdy[2]), .lockup(out_lk[2]));

  assign out_wo[0] = 32'(wo_a);
  assign out_wo[1] = 32'(wo_b);
  assign out_wo[2] = 32'(wo_c);

  function automatic mstate_t reset_state(input int k);
    mstate_t s;
    s.sr = CFG_SEED[k]; s.acc = '0; s.nbits = 0; s.wo = '0;
    s.rb = 1'b0; s.wv = 1'b0; s.lk = 1'b0;
    return s;
  endfunction

  // One clock of the specified behaviour: bits are gathered into an
  // accumulator, a full word is published, an unread word blocks the last bit.
  function automatic mstate_t model_next(input mstate_t s, input int k, input logic e,
                                         input logic r, input logic [31:0] seed, input logic rd);
    mstate_t     n;
    logic [31:0] nmask, wmask, sv;
    logic        b, stall;
    n     = s;
    nmask = (32'h1 << CFG_N[k]) - 32'h1;
    wmask = (32'h1 << CFG_W[k]) - 32'h1;
    sv    = seed & nmask;
    stall = (s.nbits == CFG_W[k] - 1) && s.wv && !rd;
    n.lk  = 1'b0;
    if (s.wv && rd) n.wv = 1'b0;
    if (r) begin
      n.sr    = (sv == 0) ? CFG_SEED[k] : sv;
      n.lk    = (sv == 0);
      n.nbits = 0;
      n.acc   = '0;
    end else if (e && !stall) begin
      b     = s.sr[CFG_N[k]-1];
      n.rb  = b;
      n.acc = ((s.acc << 1) | 32'(b)) & wmask;
      if (CFG_GAL[k] != 0)
        n.sr = ((s.sr << 1) & nmask) ^ (b ? CFG_TAPS[k] : 32'h0);
      else
        n.sr = ((s.sr << 1) & nmask) | 32'($countones(s.sr & CFG_TAPS[k]) % 2);
      n.nbits = s.nbits + 1;
      if (n.nbits == CFG_W[k]) begin
        n.nbits = 0;
        n.wo    = n.acc;
        n.wv    = 1'b1;
      end
    end
    return n;
  endfunction

  function automatic int model_period(input int k);
    mstate_t     s;
    logic [31:0] start;
    s     = reset_state(k);
    start = s.sr;
    for (int i = 1; i <= 100; i++) begin
      s = model_next(s, k, 1'b1, 1'b0, 32'h0, 1'b1);
      if (s.sr == start) return i;
    end
    return -1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model follows the DUTs, reset included.
  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 3; k++) begin
      if (!rst_n) m_q[k] <= reset_state(k);
      else        m_q[k] <= model_next(m_q[k], k, en[k], rs[k], sd[k], rdy[k]);
    end
  end

  // Every cycle: all DUT outputs against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("model_rb[%0d]", k), 32'(out_rb[k]), 32'(m_q[k].rb));
        chk($sformatf("model_wv[%0d]", k), 32'(out_wv[k]), 32'(m_q[k].wv));
        chk($sformatf("model_lk[%0d]", k), 32'(out_lk[k]), 32'(m_q[k].lk));
        if (m_q[k].wv || out_wv[k])
          chk($sformatf("model_wo[%0d]", k), out_wo[k], m_q[k].wo);
      end
    end
  end

  // Advance n clock edges and return just after the following falling edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic quiet_inputs();
    for (int k = 0; k < 3; k++) begin
      en[k] = 1'b0; rs[k] = 1'b0; sd[k] = '0; rdy[k] = 1'b0;
    end
  endtask

  task automatic do_reset();
    quiet_inputs();
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
  endtask

  logic rb_a [62];
  logic rb_b [62];

  initial begin
    int ones, diffs;
    quiet_inputs();
    rst_n = 1'b0;
    tick(2);
    cmp_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("reset_rb[%0d]", k), 32'(out_rb[k]), 32'h0);
      chk($sformatf("reset_wv[%0d]", k), 32'(out_wv[k]), 32'h0);
      chk($sformatf("reset_wo[%0d]", k), out_wo[k], 32'h0);
    end
    rst_n = 1'b1;

    // Model pins: maximal-length periods.
    chk("model_period_fib5", 32'(model_period(0)), 32'd31);
    chk("model_period_gal4", 32'(model_period(1)), 32'd15);

    // Free running with ready high: known bit/word sequence and period.
    do_reset();
    en[0] = 1'b1; rdy[0] = 1'b1; en[1] = 1'b1; rdy[1] = 1'b1;
    for (int i = 0; i < 62; i++) begin
      tick(1);
      rb_a[i] = out_rb[0];
      rb_b[i] = out_rb[1];
      if (i == 4) begin
        chk("first_word_a", out_wo[0], 32'h01);
        chk("first_valid_a", 32'(out_wv[0]), 32'h1);
      end
      if (i == 9) begin
        chk("second_word_a", out_wo[0], 32'h0B);
        chk("second_valid_a", 32'(out_wv[0]), 32'h1);
      end
    end
    chk("first_bits_a", {27'h0, rb_a[0], rb_a[1], rb_a[2], rb_a[3], rb_a[4]}, 32'h01);
    ones = 0; diffs = 0;
    for (int i = 0; i < 31; i++) begin
      ones += int'(rb_a[i]);
      if (rb_a[i] !== rb_a[i+31]) diffs++;
    end
    chk("ones_per_period_a", 32'(ones), 32'd16);
    chk("period_31_a", 32'(diffs), 32'd0);
    ones = 0; diffs = 0;
    for (int i = 0; i < 15; i++) ones += int'(rb_b[i]);
    for (int i = 0; i < 47; i++) if (rb_b[i] !== rb_b[i+15]) diffs++;
    chk("ones_per_period_b", 32'(ones), 32'd8);
    chk("period_15_b", 32'(diffs), 32'd0);

    // Back-pressure on the 16-bit generator.
    do_reset();
    en[2] = 1'b1;
    tick(8);
    chk("stall_first_valid", 32'(out_wv[2]), 32'h1);
    chk("stall_first_word", out_wo[2], 32'h00);
    tick(20);
    chk("stall_hold_word", out_wo[2], 32'h00);
    chk("stall_hold_valid", 32'(out_wv[2]), 32'h1);
    rdy[2] = 1'b1;
    tick(1);
    chk("stall_release_word", out_wo[2], 32'h01);
    chk("stall_release_valid", 32'(out_wv[2]), 32'h1);
    rdy[2] = 1'b0;

    // Reseed: zero seed lockup pulse, nonzero seed, pending word kept.
    do_reset();
    en[0] = 1'b1;
    tick(6);
    en[0] = 1'b0; rs[0] = 1'b1; sd[0] = 32'h0;
    tick(1);
    chk("lockup_pulse", 32'(out_lk[0]), 32'h1);
    chk("reseed_keeps_valid", 32'(out_wv[0]), 32'h1);
    rs[0] = 1'b0;
    tick(1);
    chk("lockup_one_cycle", 32'(out_lk[0]), 32'h0);
    rs[0] = 1'b1; sd[0] = 32'h1F;
    tick(1);
    chk("no_lockup_nonzero", 32'(out_lk[0]), 32'h0);
    chk("reseed1f_keeps_valid", 32'(out_wv[0]), 32'h1);
    rs[0] = 1'b0; en[0] = 1'b1; rdy[0] = 1'b1;
    tick(5);
    chk("word_after_1f", out_wo[0], 32'h1F);

    // Asynchronous reset in the middle of a word.
    do_reset();
    en[0] = 1'b1;
    tick(8);
    rst_n = 1'b0;
    #1;
    chk("async_rst_rb", 32'(out_rb[0]), 32'h0);
    chk("async_rst_wv", 32'(out_wv[0]), 32'h0);
    chk("async_rst_wo", out_wo[0], 32'h0);
    chk("async_rst_lk", 32'(out_lk[0]), 32'h0);
    @(negedge clk); #1;
    rst_n = 1'b1; en[0] = 1'b1; rdy[0] = 1'b1;
    tick(5);
    chk("first_word_after_rst", out_wo[0], 32'h01);

    // Randomised traffic with occasional mid-cycle resets.
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < 3; k++) begin
        en[k]  = ($urandom_range(0, 9) != 0);
        rs[k]  = ($urandom_range(0, 29) == 0);
        sd[k]  = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
        rdy[k] = ($urandom_range(0, 2) != 0);
      end
      if ($urandom_range(0, 399) == 0) rst_n = 1'b0;
      tick(1);
      rst_n = 1'b1;
    end

    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
